// File: rtl/l1_data_cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate L1 data cache controller.
// Sequences the set array between a CPU load/store port and the L2/memory port.
module l1_data_cache_ctrl #(
  parameter int BLOCK_SIZE = 128,
  parameter int TAG_SIZE   = 9,
  parameter int IDX_SIZE   = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cpu_req_i,
  input  logic                         cpu_we_i,
  input  logic [TAG_SIZE+IDX_SIZE+3:0] cpu_addr_i,
  input  logic [31:0]                  cpu_wdata_i,
  input  logic [3:0]                   cpu_be_i,
  output logic                         cpu_ready_o,
  output logic                         cpu_ack_o,
  output logic [31:0]                  cpu_rdata_o,
  output logic [TAG_SIZE+IDX_SIZE-1:0] arr_tag_idx_o,
  output logic                         arr_we_o,
  output logic [BLOCK_SIZE/8-1:0]      arr_be_o,
  output logic [BLOCK_SIZE-1:0]        arr_block_o,
  input  logic [BLOCK_SIZE-1:0]        arr_block_i,
  input  logic                         arr_valid_i,
  input  logic [TAG_SIZE-1:0]          arr_tag_i,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [TAG_SIZE+IDX_SIZE+3:0] mem_addr_o,
  output logic [BLOCK_SIZE/8-1:0]      mem_be_o,
  output logic [BLOCK_SIZE-1:0]        mem_wdata_o,
  input  logic                         mem_ack_i,
  input  logic [BLOCK_SIZE-1:0]        mem_rdata_i,
  output logic [CNT_WIDTH-1:0]         hit_cnt_o,
  output logic [CNT_WIDTH-1:0]         miss_cnt_o
);

  localparam int ADDR_W = TAG_SIZE + IDX_SIZE + 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WR_MEM  = 3'd2,
    REFILL  = 3'd3,
    FILL_WR = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_we;
  logic [31:0]             r_wdata;
  logic [3:0]              r_be;
  logic [BLOCK_SIZE-1:0]   r_line;
  logic [31:0]             r_rdata;
  logic [CNT_WIDTH-1:0]    r_hit_cnt;
  logic [CNT_WIDTH-1:0]    r_miss_cnt;

  logic [TAG_SIZE-1:0]     w_tag;
  logic [1:0]              w_word;
  logic                    w_hit;
  logic [15:0]             w_be16;
  logic [BLOCK_SIZE-1:0]   w_wdata4;

  function automatic logic [31:0] sel_word(input logic [BLOCK_SIZE-1:0] line,
                                           input logic [1:0] word);
    return line[{word, 5'b00000} +: 32];
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign w_tag    = r_addr[ADDR_W-1 -: TAG_SIZE];
  assign w_word   = r_addr[3:2];
  assign w_hit    = arr_valid_i && (arr_tag_i == w_tag);
  assign w_be16   = 16'(r_be) << {w_word, 2'b00};
  assign w_wdata4 = {4{r_wdata}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_line     <= '0;
      r_rdata    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req_i) begin
            r_addr  <= cpu_addr_i;
            r_we    <= cpu_we_i;
            r_wdata <= cpu_wdata_i;
            r_be    <= cpu_be_i;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
          else       r_miss_cnt <= sat_inc(r_miss_cnt);
          if (r_we) begin
            r_state <= WR_MEM;
          end else if (w_hit) begin
            r_rdata <= sel_word(arr_block_i, w_word);
            r_state <= RESP;
          end else begin
            r_state <= REFILL;
          end
        end
        WR_MEM: begin
          if (mem_ack_i) r_state <= RESP;
        end
        REFILL: begin
          if (mem_ack_i) begin
            r_line  <= mem_rdata_i;
            r_rdata <= sel_word(mem_rdata_i, w_word);
            r_state <= FILL_WR;
          end
        end
        FILL_WR: r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state and request.
  always_comb begin
    cpu_ready_o = (r_state == IDLE);
    cpu_ack_o   = (r_state == RESP);
    cpu_rdata_o = (r_state == RESP && r_we) ? 32'h0 : r_rdata;
    arr_we_o    = 1'b0;
    arr_be_o    = '0;
    arr_block_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    case (r_state)
      LOOKUP: begin
        if (r_we && w_hit) begin
          arr_we_o    = 1'b1;
          arr_be_o    = w_be16;
          arr_block_o = w_wdata4;
        end
      end
      WR_MEM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = r_addr;
        mem_be_o    = w_be16;
        mem_wdata_o = w_wdata4;
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {r_addr[ADDR_W-1:4], 4'b0000};
      end
      FILL_WR: begin
        arr_we_o    = 1'b1;
        arr_be_o    = '1;
        arr_block_o = r_line;
      end
      default: ;
    endcase
  end

  assign arr_tag_idx_o = r_addr[ADDR_W-1:4];
  assign hit_cnt_o     = r_hit_cnt;
  assign miss_cnt_o    = r_miss_cnt;

endmodule
